// File: rtl/baccarat_engine.sv
`default_nettype none
// ============================================================================
// Module   : baccarat_engine
// Purpose  : Baccarat round engine. Deals one externally supplied card per
//            advance, applies the player/banker third-card rules, keeps
//            saturating win/loss/tie tallies and tracks a finite shoe with
//            an empty flag and a reshuffle reload.
// Revision : 1.0  initial parametrised release
// ----------------------------------------------------------------------------
// Ports
//   CLOCK_50              in   system clock, rising edge
//   reset                 in   asynchronous active-high reset
//   step                  in   one-cycle advance pulse (debounced, edge-detected)
//   auto                  in   deal states other than P1 advance every cycle
//   reshuffle             in   one-cycle pulse, reloads the shoe
//   card_in[3:0]          in   card to deal (1 = A, 11..13 = J/Q/K)
//   pcard1..3, dcard1..3  out  dealt cards, 0 = not dealt
//   pscore, dscore        out  hand value mod 10 (combinational)
//   player_win/dealer_win out  round result, only in DONE, both 0 on a tie
//   round_done            out  high while in DONE
//   p_tally/d_tally/t_tally out saturating player/dealer/tie counts
//   cards_left            out  cards remaining in the shoe
//   shoe_empty            out  cards_left == 0
// ============================================================================
module baccarat_engine #(
  parameter int  TALLY_W    = 8,
  parameter int  SHOE_DEPTH = 52,
  localparam int CL_W       = $clog2(SHOE_DEPTH + 1)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               step,
  input  logic               auto,
  input  logic               reshuffle,
  input  logic [3:0]         card_in,
  output logic [3:0]         pcard1,
  output logic [3:0]         pcard2,
  output logic [3:0]         pcard3,
  output logic [3:0]         dcard1,
  output logic [3:0]         dcard2,
  output logic [3:0]         dcard3,
  output logic [3:0]         pscore,
  output logic [3:0]         dscore,
  output logic               player_win,
  output logic               dealer_win,
  output logic               round_done,
  output logic [TALLY_W-1:0] p_tally,
  output logic [TALLY_W-1:0] d_tally,
  output logic [TALLY_W-1:0] t_tally,
  output logic [CL_W-1:0]    cards_left,
  output logic               shoe_empty
);

  localparam logic [CL_W-1:0]    C_SHOE_FULL = CL_W'(SHOE_DEPTH);
  localparam logic [TALLY_W-1:0] C_TALLY_MAX = '1;

  // S_SETTLE sits between the fourth card and the natural check, so the
  // two-card decision happens one cycle after the last initial card is shown.
  typedef enum logic [3:0] {
    S_P1     = 4'd0,
    S_D1     = 4'd1,
    S_P2     = 4'd2,
    S_D2     = 4'd3,
    S_SETTLE = 4'd4,
    S_CHK    = 4'd5,
    S_P3     = 4'd6,
    S_CHK3   = 4'd7,
    S_D3     = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  state_t             r_state;
  logic [3:0]         r_pcard1, r_pcard2, r_pcard3;
  logic [3:0]         r_dcard1, r_dcard2, r_dcard3;
  logic               r_player_win, r_dealer_win, r_round_done;
  logic [TALLY_W-1:0] r_p_tally, r_d_tally, r_t_tally;
  logic [CL_W-1:0]    r_cards_left;

  logic [3:0] w_pscore, w_dscore, w_final_d, w_v3;
  logic       w_shoe_empty, w_deal_state, w_advance, w_natural;
  logic       w_banker_draws, w_enter_done;

  // Card point value: only 1..9 count, 0 and 10..15 are worth nothing.
  function automatic logic [3:0] card_value(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
  endfunction

  // Sum of up to three card values, reduced mod 10 (sum never exceeds 27).
  function automatic logic [3:0] hand_score(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [3:0] c);
    logic [4:0] s;
    logic [4:0] m;
    s = {1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)};
    if (s >= 5'd20)      m = s - 5'd20;
    else if (s >= 5'd10) m = s - 5'd10;
    else                 m = s;
    return m[3:0];
  endfunction

  assign w_pscore     = hand_score(r_pcard1, r_pcard2, r_pcard3);
  assign w_dscore     = hand_score(r_dcard1, r_dcard2, r_dcard3);
  assign w_v3         = card_value(r_pcard3);
  assign w_shoe_empty = (r_cards_left == '0);
  assign w_natural    = (w_pscore >= 4'd8) || (w_dscore >= 4'd8);

  assign w_deal_state = (r_state == S_P1) || (r_state == S_D1) ||
                        (r_state == S_P2) || (r_state == S_D2) ||
                        (r_state == S_P3) || (r_state == S_D3);

  // A deal needs a card in the shoe; a reshuffle in the same cycle wins and
  // the deal is dropped.
  assign w_advance = w_deal_state && (step || (auto && (r_state != S_P1))) &&
                     !w_shoe_empty && !reshuffle;

  // Banker score used for the result: when DONE is entered from D3 the third
  // banker card is still on card_in, so fold it in directly.
  assign w_final_d = (r_state == S_D3) ? hand_score(r_dcard1, r_dcard2, card_in)
                                       : w_dscore;

  // Banker tableau after the player has drawn a third card.
  always_comb begin
    w_banker_draws = 1'b0;
    case (w_dscore)
      4'd0, 4'd1, 4'd2: w_banker_draws = 1'b1;
      4'd3:             w_banker_draws = (w_v3 != 4'd8);
      4'd4:             w_banker_draws = (w_v3 >= 4'd2) && (w_v3 <= 4'd7);
      4'd5:             w_banker_draws = (w_v3 >= 4'd4) && (w_v3 <= 4'd7);
      4'd6:             w_banker_draws = (w_v3 >= 4'd6) && (w_v3 <= 4'd7);
      default:          w_banker_draws = 1'b0;
    endcase
  end

  always_comb begin
    w_enter_done = 1'b0;
    case (r_state)
      S_CHK:   w_enter_done = w_natural ||
                              ((w_pscore > 4'd5) && (w_dscore > 4'd5));
      S_CHK3:  w_enter_done = !w_banker_draws;
      S_D3:    w_enter_done = w_advance;
      default: w_enter_done = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= S_P1;
      r_pcard1     <= 4'd0;
      r_pcard2     <= 4'd0;
      r_pcard3     <= 4'd0;
      r_dcard1     <= 4'd0;
      r_dcard2     <= 4'd0;
      r_dcard3     <= 4'd0;
      r_player_win <= 1'b0;
      r_dealer_win <= 1'b0;
      r_round_done <= 1'b0;
      r_p_tally    <= '0;
      r_d_tally    <= '0;
      r_t_tally    <= '0;
      r_cards_left <= C_SHOE_FULL;
    end else begin
      // Shoe bookkeeping: every accepted deal consumes one card.
      if (reshuffle)
        r_cards_left <= C_SHOE_FULL;
      else if (w_advance)
        r_cards_left <= r_cards_left - 1'b1;

      // Result flags and tallies settle on the edge that enters DONE.
      if (w_enter_done) begin
        r_round_done <= 1'b1;
        r_player_win <= (w_pscore > w_final_d);
        r_dealer_win <= (w_final_d > w_pscore);
        if (w_pscore > w_final_d) begin
          if (r_p_tally != C_TALLY_MAX) r_p_tally <= r_p_tally + 1'b1;
        end else if (w_final_d > w_pscore) begin
          if (r_d_tally != C_TALLY_MAX) r_d_tally <= r_d_tally + 1'b1;
        end else begin
          if (r_t_tally != C_TALLY_MAX) r_t_tally <= r_t_tally + 1'b1;
        end
      end

      case (r_state)
        S_P1: if (w_advance) begin
          r_pcard1 <= card_in;
          r_state  <= S_D1;
        end
        S_D1: if (w_advance) begin
          r_dcard1 <= card_in;
          r_state  <= S_P2;
        end
        S_P2: if (w_advance) begin
          r_pcard2 <= card_in;
          r_state  <= S_D2;
        end
        S_D2: if (w_advance) begin
          r_dcard2 <= card_in;
          r_state  <= S_SETTLE;
        end
        S_SETTLE: r_state <= S_CHK;
        S_CHK: begin
          if (w_enter_done)             r_state <= S_DONE;
          else if (w_pscore <= 4'd5)    r_state <= S_P3;
          else                          r_state <= S_D3;
        end
        S_P3: if (w_advance) begin
          r_pcard3 <= card_in;
          r_state  <= S_CHK3;
        end
        S_CHK3: r_state <= w_banker_draws ? S_D3 : S_DONE;
        S_D3: if (w_advance) begin
          r_dcard3 <= card_in;
          r_state  <= S_DONE;
        end
        S_DONE: if (step) begin
          // New round: clear the table, keep tallies and the shoe.
          r_pcard1     <= 4'd0;
          r_pcard2     <= 4'd0;
          r_pcard3     <= 4'd0;
          r_dcard1     <= 4'd0;
          r_dcard2     <= 4'd0;
          r_dcard3     <= 4'd0;
          r_player_win <= 1'b0;
          r_dealer_win <= 1'b0;
          r_round_done <= 1'b0;
          r_state      <= S_P1;
        end
        default: r_state <= S_P1;
      endcase
    end
  end

  assign pcard1     = r_pcard1;
  assign pcard2     = r_pcard2;
  assign pcard3     = r_pcard3;
  assign dcard1     = r_dcard1;
  assign dcard2     = r_dcard2;
  assign dcard3     = r_dcard3;
  assign pscore     = w_pscore;
  assign dscore     = w_dscore;
  assign player_win = r_player_win;
  assign dealer_win = r_dealer_win;
  assign round_done = r_round_done;
  assign p_tally    = r_p_tally;
  assign d_tally    = r_d_tally;
  assign t_tally    = r_t_tally;
  assign cards_left = r_cards_left;
  assign shoe_empty = w_shoe_empty;

endmodule
`default_nettype wire
